// File: rtl/program_sequencer_pkg.sv
// Shared opcode constants and sequencer state encoding.
// The ICU decodes the same control-flow opcodes as non-ALU.
package seq_defs;

    localparam logic [3:0] OP_HALT = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_CALL = 4'hE;
    localparam logic [3:0] OP_RET  = 4'hF;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } seq_state_e;

endpackage

// File: rtl/program_sequencer_if.sv
// ROM-side bundle of the program sequencer.
// The master drives the instruction fields, the slave drives the address.
interface program_sequencer_if #(
    parameter int N           = 4,
    parameter int STACK_DEPTH = 2
);
    localparam int SW = $clog2(STACK_DEPTH + 1);

    logic          step_en;
    logic [3:0]    opcode;
    logic [3:0]    operand;
    logic          zed;
    logic [N-1:0]  addr;
    logic          halted;
    logic          stack_err;
    logic [SW-1:0] sp;

    modport master (
        output step_en, opcode, operand, zed,
        input  addr, halted, stack_err, sp
    );

    modport slave (
        input  step_en, opcode, operand, zed,
        output addr, halted, stack_err, sp
    );

endinterface

// File: rtl/program_sequencer_return_stack.sv
// LIFO of return addresses for CALL/RET.
// Only the occupancy count is reset; entry contents are don't-care.
module return_stack #(
    parameter int N           = 4,
    parameter int STACK_DEPTH = 2,
    localparam int SW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [N-1:0]  din_i,
    output logic [N-1:0]  top_o,
    output logic [SW-1:0] sp_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [N-1:0]  mem_q [STACK_DEPTH];
    logic [SW-1:0] sp_q;
    logic [SW-1:0] sp_d;

    assign full_o  = (sp_q == SW'(STACK_DEPTH));
    assign empty_o = (sp_q == '0);
    assign sp_o    = sp_q;

    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o) begin
            sp_d = sp_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push_i && !full_o && sp_q == SW'(i)) begin
                mem_q[i] <= din_i;
            end
        end
    end

    // Top of stack is the entry just below the occupancy count.
    always_comb begin
        top_o = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SW'(i + 1)) begin
                top_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// ROM address sequencer with jump, conditional jump, call/return and halt.
// Control flow resolves at the next edge; there is no delay slot.
module program_sequencer
    import seq_defs::*;
#(
    parameter int N           = 4,
    parameter int STACK_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    program_sequencer_if.slave   bus
);

    localparam int SW = $clog2(STACK_DEPTH + 1);

    seq_state_e    state_q, state_d;
    logic [N-1:0]  addr_q, addr_d;
    logic          err_q, err_d;
    logic          push, pop;
    logic [N-1:0]  inc, tgt, top;
    logic [SW-1:0] sp;
    logic          full, empty;

    assign inc = addr_q + 1'b1;
    assign tgt = N'(bus.operand);

    return_stack #(
        .N           (N),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (inc),
        .top_o   (top),
        .sp_o    (sp),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (bus.step_en && state_q == ST_RUN) begin
            unique case (1'b1)
                (bus.opcode == OP_HALT): state_d = ST_HALT;
                (bus.opcode == OP_JMP):  addr_d  = tgt;
                (bus.opcode == OP_JZ):   addr_d  = bus.zed ? tgt : inc;
                (bus.opcode == OP_CALL): begin
                    if (full) begin
                        addr_d = inc;
                        err_d  = 1'b1;
                    end else begin
                        push   = 1'b1;
                        addr_d = tgt;
                    end
                end
                (bus.opcode == OP_RET): begin
                    if (empty) begin
                        addr_d = inc;
                        err_d  = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        addr_d = top;
                    end
                end
                default: addr_d = inc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign bus.addr      = addr_q;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.stack_err = err_q;
    assign bus.sp        = sp;

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Upstream stage of the program ROM. Replaces the free-running program counter with a sequencer that generates the ROM address every cycle.
- Decodes the instruction's control-flow opcodes: jump, jump-if-zero, call, return and halt. All other opcodes fall through to increment.
- Holds a small hardware return stack for call/return.
- Consumes the ROM instruction (opcode/operand fields) and the ICU zero flag; drives the ROM address.

Parameters:
- N, 4, program address width; ROM depth is 2^N.
- STACK_DEPTH, 2, return-stack entries (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- step_en  input  1  advance enable; 0 freezes all state.
- opcode  input  4  instruction[7:4] from ROM.
- operand  input  4  instruction[3:0] from ROM; the jump/call target.
- zed  input  1  zero flag from the ICU.
- addr  output  N  ROM address (registered).
- halted  output  1  sequencer stopped by HALT.
- stack_err  output  1  sticky error on call overflow or return underflow.
- sp  output  clog2(STACK_DEPTH+1)  current return-stack occupancy.

Behaviour:
- Reset (async, immediate): addr=0, sp=0, halted=0, stack_err=0; stack contents are don't-care.
- ROM is combinational, so the instruction at addr is valid in the same cycle. Control flow therefore takes effect at the next rising edge: one-cycle latency, no delay slot.
- Target T = operand zero-extended to N bits when N>4, or its low N bits when N<4.
- inc = addr+1 mod 2^N; 2^N-1 wraps to 0 with no flag.
- The following applies only on an edge with step_en=1 and halted=0. Otherwise every register holds.
- OP_JMP: addr<=T.
- OP_JZ: addr<=T if zed=1, else addr<=inc. zed is sampled at the edge.
- OP_CALL with sp<STACK_DEPTH: push inc at stack[sp], sp<=sp+1, addr<=T.
- OP_CALL with sp==STACK_DEPTH (full): no push, no jump, addr<=inc, stack_err<=1.
- OP_RET with sp>0: addr<=stack[sp-1], sp<=sp-1.
- OP_RET with sp==0 (empty): addr<=inc, stack_err<=1.
- OP_HALT: halted<=1 and addr holds at the HALT instruction. Only rst clears halted.
- Any other opcode: addr<=inc.
- stack_err is sticky and cleared only by rst. Later calls and returns behave normally after an error.
- Reset asserted mid-operation overrides everything asynchronously. On the first edge after rst deasserts, the sequencer executes the instruction at address 0.
- step_en=0 while a CALL is presented: nothing is pushed. The call executes on the first enabled edge.

State machine:
- Two states: RUN and HALT.
- RUN goes to HALT on an enabled edge that decodes OP_HALT.
- HALT goes to RUN only via rst.

Decomposition:
- Shared package (seq_defs):
  - OP_HALT=4'hB, OP_JMP=4'hC, OP_JZ=4'hD, OP_CALL=4'hE, OP_RET=4'hF.
  - The ICU uses the same constants and treats these opcodes as non-ALU (no write).
- One sub-module, return_stack:
  - Parameters N and STACK_DEPTH.
  - Inputs push, pop, din; outputs top, sp, full, empty.
  - LIFO register file with synchronous push/pop and async reset of sp.
  - push and pop are never asserted together.
- The sequencer core holds the addr/halted/stack_err registers and the next-address mux.

Test Plan:
- Reset and increment: rst pulse, step_en=1, opcode=0 for 18 cycles. Required: addr 0,1,…,15,0,1; halted=0; stack_err=0.
- Jumps: JMP 0x9 at addr 2 → next addr 9. JZ 0x3 with zed=0 → addr+1. JZ 0x3 with zed=1 → addr 3.
- Call/return: CALL 0x8 at addr 1 → addr 8, sp=1. CALL 0xC at addr 8 → addr C, sp=2. RET → addr 9, sp=1. RET → addr 2, sp=0. stack_err stays 0 throughout.
- Stack errors (STACK_DEPTH=2, sp=2): CALL at addr 5 → addr 6, sp=2, stack_err=1. Then with sp=0: RET at addr 7 → addr 8; stack_err remains 1 until rst.
- Halt and enable: HALT at addr 4 → addr stays 4 and halted=1 for 10 cycles despite any opcode. step_en=0 during a JMP → addr frozen; raising step_en → jump taken on that edge.
- Async reset: assert rst between clock edges while addr=A, sp=1, halted=1. Required: addr=0, sp=0, halted=0 immediately, before the next edge.
